// File: rtl/agc_pkg.sv
// agc_pkg: shared types, widths and helpers for the AGC shift controller.
package agc_pkg;
  typedef enum logic [1:0] {IDLE, LZC, DECIDE} state_e;
  localparam int LZ_W = 6;
  localparam int SH_W = 5;
  function automatic logic [31:0] sat_abs(input logic [31:0] x);
    return x[31] ? ((x == 32'h8000_0000) ? 32'h7FFF_FFFF : (~x + 32'd1)) : x;
  endfunction
  function automatic logic [SH_W-1:0] clamp_shift(input int v, input int max_v);
    return SH_W'((v < 0) ? 0 : ((v > max_v) ? max_v : v));
  endfunction
endpackage

// File: rtl/agc_shift_ctrl_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter, 32 for an all-zero input.
module lzc32
  import agc_pkg::*;
(
  input  logic [31:0]     x,
  output logic [LZ_W-1:0] lz
);
  always_comb begin
    lz = LZ_W'(32);
    for (int i = 0; i < 32; i++) lz = x[i] ? LZ_W'(31 - i) : lz;
  end
endmodule

// File: rtl/agc_shift_ctrl.sv
// agc_shift_ctrl: windowed-peak AGC producing the gain-adjust left shift.
// Define AGC_MANUAL_OVERRIDE_EN to add the manual_en/manual_shift override.
module agc_shift_ctrl
  import agc_pkg::*;
#(
  parameter int WIN_LOG2   = 10,
  parameter int HEADROOM   = 1,
  parameter int MAX_SHIFT  = 16,
  parameter int INIT_SHIFT = 0,
  parameter int HOLD       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] din,
  input  logic        din_valid,
`ifdef AGC_MANUAL_OVERRIDE_EN
  input  logic        manual_en,
  input  logic [4:0]  manual_shift,
`endif
  output logic [15:0] scaled_coeff,
  output logic        shift_valid,
  output logic        clip
);
  localparam logic [7:0] HOLD_C = 8'(HOLD);
  state_e state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [31:0] peak_q, peak_d, snap_q, snap_d, mag, peak_new;
  logic [LZ_W-1:0] lz_q, lz_d, lz_w;
  logic [SH_W-1:0] tgt_q, tgt_d, cur_q, cur_d, man_shift;
  logic [7:0] hold_q, hold_d, hold_inc;
  logic apply_q, apply_d, sv_q, sv_d, clip_q, clip_d;
  logic samp, win_end, ld_lz, ld_tgt, man, up, dn;

`ifdef AGC_MANUAL_OVERRIDE_EN
  assign man       = manual_en;
  assign man_shift = clamp_shift(int'(manual_shift), MAX_SHIFT);
`else
  assign man       = 1'b0;
  assign man_shift = '0;
`endif

  lzc32 u_lzc (.x(snap_q), .lz(lz_w));

  // The counter wraps to zero on the last sample, so the next window starts with no gap.
  always_comb begin
    mag      = sat_abs(din);
    samp     = enable && din_valid;
    peak_new = (mag > peak_q) ? mag : peak_q;
    win_end  = samp && (&cnt_q);
    cnt_d    = !enable ? '0 : (samp ? cnt_q + 1'b1 : cnt_q);
    peak_d   = (!enable || win_end) ? '0 : (samp ? peak_new : peak_q);
    snap_d   = win_end ? peak_new : snap_q;
    clip_d   = samp && ((mag >> (5'd31 - cur_q)) != 32'd0);
  end

  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = (state_q == IDLE) ? (win_end ? LZC : IDLE) :
              (state_q == LZC)  ? DECIDE : IDLE;
  end

  always_comb begin
    ld_lz  = (state_q == LZC);
    ld_tgt = (state_q == DECIDE);
  end

  always_comb begin
    lz_d     = ld_lz ? lz_w : lz_q;
    tgt_d    = ld_tgt ? clamp_shift(int'(lz_q) - HEADROOM, MAX_SHIFT) : tgt_q;
    apply_d  = ld_tgt;
    sv_d     = apply_q;
    hold_inc = hold_q + 8'd1;
    up       = tgt_q > cur_q;
    dn       = tgt_q < cur_q;
    cur_d    = man ? man_shift :
               !apply_q ? cur_q :
               dn ? tgt_q :
               (up && hold_inc >= HOLD_C) ? cur_q + 1'b1 : cur_q;
    hold_d   = (man || !enable) ? '0 :
               !apply_q ? hold_q :
               (up && hold_inc < HOLD_C) ? hold_inc : '0;
  end

  always_ff @(posedge clk)
    if (rst) begin
      cnt_q   <= '0;
      peak_q  <= '0;
      snap_q  <= '0;
      lz_q    <= '0;
      tgt_q   <= '0;
      cur_q   <= SH_W'(INIT_SHIFT);
      hold_q  <= '0;
      apply_q <= 1'b0;
      sv_q    <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      snap_q  <= snap_d;
      lz_q    <= lz_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
      apply_q <= apply_d;
      sv_q    <= sv_d;
      clip_q  <= clip_d;
    end

  assign scaled_coeff = {{(16 - SH_W){1'b0}}, cur_q};
  assign shift_valid  = sv_q;
  assign clip         = clip_q;
endmodule

// File: tb/tb_agc_shift_ctrl.sv
// tb_agc_shift_ctrl: directed bench with a per-cycle window/decision model.
module tb_agc_shift_ctrl;
  localparam int WIN = 16;
  localparam int MAXS = 16;
  localparam int HOLD = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic [31:0] din = '0;
  logic din_valid = 1'b0;
  logic [15:0] scaled_coeff;
  logic shift_valid, clip;
`ifdef AGC_MANUAL_OVERRIDE_EN
  logic manual_en = 1'b0;
  logic [4:0] manual_shift = '0;
`endif
  int errs = 0;
  int checks = 0;
  bit chk_on = 0;

  agc_shift_ctrl #(.WIN_LOG2(4), .HEADROOM(1), .MAX_SHIFT(MAXS), .INIT_SHIFT(0), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .din_valid(din_valid),
`ifdef AGC_MANUAL_OVERRIDE_EN
    .manual_en(manual_en), .manual_shift(manual_shift),
`endif
    .scaled_coeff(scaled_coeff), .shift_valid(shift_valid), .clip(clip));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: collect magnitudes per window, derive target from the peak's bit length.
  int cyc = 0;
  int m_coeff = 0, m_hold = 0, w_n = 0;
  longint w_pk = 0;
  bit m_sv = 0, m_clip = 0;
  int due_q[$], tgt_q[$];

  function automatic longint mag_of(input logic [31:0] x);
    longint s = longint'($signed(x));
    s = (s < 0) ? -s : s;
    return (s > 2147483647) ? 2147483647 : s;
  endfunction

  always @(posedge clk) begin
    int old, t, lz;
    longint m;
    cyc++;
    if (rst) begin
      m_coeff = 0; m_hold = 0; w_n = 0; w_pk = 0; m_sv = 0; m_clip = 0;
      due_q.delete(); tgt_q.delete();
    end else begin
      old = m_coeff; m_sv = 0; m_clip = 0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        t = tgt_q.pop_front();
        m_sv = 1;
        if (t < m_coeff) begin m_coeff = t; m_hold = 0; end
        else if (t > m_coeff) begin
          m_hold++;
          if (m_hold == HOLD) begin m_coeff++; m_hold = 0; end
        end else m_hold = 0;
      end
      if (enable && din_valid) begin
        m = mag_of(din);
        m_clip = (m >= (64'sd1 <<< (31 - old)));
        w_n++;
        if (m > w_pk) w_pk = m;
        if (w_n == WIN) begin
          lz = 32 - $clog2(w_pk + 1);
          t = lz - 1;
          t = (t < 0) ? 0 : ((t > MAXS) ? MAXS : t);
          due_q.push_back(cyc + 3);
          tgt_q.push_back(t);
          w_n = 0; w_pk = 0;
        end
      end
      if (!enable) begin w_n = 0; w_pk = 0; m_hold = 0; end
    end
  end

  always @(negedge clk)
    if (chk_on) begin
      chk("coeff_model", {16'd0, scaled_coeff}, m_coeff);
      chk("valid_model", {31'd0, shift_valid}, {31'd0, m_sv});
      chk("clip_model", {31'd0, clip}, {31'd0, m_clip});
    end

  task automatic feed(input logic [31:0] v, input int n);
    repeat (n) begin
      din = v; din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0; din = '0;
  endtask

  task automatic wait_eval(output int lat);
    lat = 1;
    while (!shift_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic no_eval(input string nm);
    bit seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (shift_valid) seen = 1;
    end
    chk(nm, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("reset_coeff", {16'd0, scaled_coeff}, 32'd0);
    chk("reset_valid", {31'd0, shift_valid}, 32'd0);
    chk("reset_clip", {31'd0, clip}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 1; w <= 34; w++) begin
      feed(32'h0000_1000, WIN);
      wait_eval(lat);
      chk("ramp_latency", lat, 32'd4);
      if (w == 2) chk("ramp_w2", {16'd0, scaled_coeff}, 32'd1);
      if (w == 32) chk("ramp_w32", {16'd0, scaled_coeff}, 32'd16);
      if (w == 34) chk("ramp_w34", {16'd0, scaled_coeff}, 32'd16);
      @(negedge clk);
    end
    din = 32'h4000_0000; din_valid = 1'b1;
    @(negedge clk);
    chk("attack_clip", {31'd0, clip}, 32'd1);
    feed(32'h0, WIN - 1);
    wait_eval(lat);
    chk("attack_latency", lat, 32'd4);
    chk("attack_coeff", {16'd0, scaled_coeff}, 32'd0);
    @(negedge clk);
    din = 32'h8000_0000; din_valid = 1'b1;
    @(negedge clk);
    chk("sat_clip", {31'd0, clip}, 32'd0);
    feed(32'h10, WIN - 1);
    wait_eval(lat);
    chk("sat_coeff", {16'd0, scaled_coeff}, 32'd0);
    chk("sat_no_x", {31'd0, $isunknown({scaled_coeff, shift_valid, clip})}, 32'd0);
    @(negedge clk);
    for (int w = 1; w <= 10; w++) begin
      feed(32'h0200_0000, WIN);
      wait_eval(lat);
      @(negedge clk);
    end
    chk("ramp_to5", {16'd0, scaled_coeff}, 32'd5);
    feed(32'h0, 2 * WIN);
    wait_eval(lat);
    chk("zero_latency", lat, 32'd4);
    chk("zero_coeff", {16'd0, scaled_coeff}, 32'd6);
    @(negedge clk);
    feed(32'h0000_1000, 7);
    enable = 1'b0;
    feed(32'h0000_1000, 3);
    enable = 1'b1;
    feed(32'h0000_1000, WIN - 1);
    no_eval("enable_no_early_eval");
    feed(32'h0000_1000, 1);
    wait_eval(lat);
    chk("enable_latency", lat, 32'd4);
    chk("enable_coeff", {16'd0, scaled_coeff}, 32'd6);
    @(negedge clk);
    feed(32'h0000_1000, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_coeff", {16'd0, scaled_coeff}, 32'd0);
    chk("midrst_valid", {31'd0, shift_valid}, 32'd0);
    rst = 1'b0;
    feed(32'h0000_1000, 11);
    no_eval("midrst_no_early_eval");
    feed(32'h0000_1000, 5);
    wait_eval(lat);
    chk("midrst_latency", lat, 32'd4);
    chk("midrst_w1", {16'd0, scaled_coeff}, 32'd0);
    @(negedge clk);
    feed(32'h0000_1000, WIN);
    wait_eval(lat);
    chk("midrst_w2", {16'd0, scaled_coeff}, 32'd1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
